// File: rtl/fft_host_stream.sv
// Host-side streaming front end for the 2048-point, 4-bank FFT core.
// It loads a frame of 16-bit samples into the core banks, starts the core and
// waits for it to finish. It then reads the 17-bit results back in natural order
// and presents them as a backpressured stream that marks the last beat.
module fft_host_stream #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic [15:0] iDATA,
    input  logic        iVALID,
    output logic        oREADY,
    output logic [16:0] oDATA,
    output logic        oVALID,
    input  logic        iREADY,
    output logic        oLAST,
    output logic        oBUSY,
    output logic [15:0] oFFT_DATA,
    output logic [8:0]  oFFT_ADDR_WR,
    output logic [3:0]  oFFT_WE,
    output logic [8:0]  oFFT_ADDR_RD,
    input  logic [16:0] iFFT_DATA_RE_0,
    input  logic [16:0] iFFT_DATA_RE_1,
    input  logic [16:0] iFFT_DATA_RE_2,
    input  logic [16:0] iFFT_DATA_RE_3,
    output logic        oFFT_START,
    input  logic        iFFT_RDY
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold fifo_count + in_flight without overflow.
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    typedef struct packed {
        logic        last;
        logic [16:0] data;
    } result_t;

    state_t  state, state_nxt;
    logic [10:0] cnt;        // load index
    logic [11:0] rd;         // read-issue index; bit 11 set once 2048 reads went out
    logic        prev_rdy;

    logic        accept, issue, push, pop, done, rdy_rise, credit_ok;

    logic [RD_LAT-1:0]       vld_pipe;
    logic [RD_LAT-1:0]       last_pipe;
    logic [RD_LAT-1:0][1:0]  bank_pipe;

    result_t     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count, in_flight;
    result_t     ret;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept   = (state == S_LOAD) && iVALID;
    assign oVALID   = (fifo_count != '0);
    assign pop      = oVALID && iREADY;
    assign done     = pop && fifo_mem[rd_ptr].last;
    assign push     = vld_pipe[RD_LAT-1];
    assign rdy_rise = iFFT_RDY && !prev_rdy;

    assign oREADY       = (state == S_LOAD);
    assign oBUSY        = (state != S_LOAD);
    assign oFFT_START   = (state == S_START);
    assign oFFT_ADDR_RD = rd[10:2];
    assign oDATA        = fifo_mem[rd_ptr].data;
    assign oLAST        = oVALID && fifo_mem[rd_ptr].last;

    // Count reads whose data is still travelling through the core read path.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++)
            in_flight = in_flight + CW'(vld_pipe[i]);
    end

    // A read may only go out if its result is guaranteed a FIFO slot on return.
    assign credit_ok = (fifo_count + in_flight) < CW'(FIFO_DEPTH);
    assign issue     = (state == S_UNLOAD) && !rd[11] && credit_ok;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   if (accept && cnt == 11'd2047) state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT:   if (rdy_rise) state_nxt = S_UNLOAD;
            S_UNLOAD: if (done) state_nxt = S_LOAD;
            default:  state_nxt = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // Previous core-ready level, so only a fresh rising edge ends WAIT.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) prev_rdy <= 1'b0;
        else        prev_rdy <= iFFT_RDY;
    end

    // Register each accepted sample onto the core write port; WE pulses one cycle.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            cnt          <= '0;
            oFFT_DATA    <= '0;
            oFFT_ADDR_WR <= '0;
            oFFT_WE      <= '0;
        end else begin
            oFFT_WE <= '0;
            if (accept) begin
                oFFT_DATA    <= iDATA;
                oFFT_ADDR_WR <= cnt[10:2];
                oFFT_WE      <= 4'b0001 << cnt[1:0];
                cnt          <= cnt + 11'd1;
            end
        end
    end

    // Read-issue counter; cleared when the last result leaves the block.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET)     rd <= '0;
        else if (done)  rd <= '0;
        else if (issue) rd <= rd + 12'd1;
    end

    // Bank select, last tag and valid follow each read through the core latency.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            bank_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= (rd[10:0] == 11'h7FF);
            bank_pipe[0] <= rd[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
            end
        end
    end

    // Pick the returning bank's data for the FIFO.
    always_comb begin
        ret.last = last_pipe[RD_LAT-1];
        case (bank_pipe[RD_LAT-1])
            2'd0:    ret.data = iFFT_DATA_RE_0;
            2'd1:    ret.data = iFFT_DATA_RE_1;
            2'd2:    ret.data = iFFT_DATA_RE_2;
            default: ret.data = iFFT_DATA_RE_3;
        endcase
    end

    // Output skid FIFO. The head register drives the stream and holds while stalled.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (done) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ret;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_host_stream.sv
// Self-checking bench for fft_host_stream. A behavioural core model holds the
// results per natural index. A negedge monitor checks every write pulse against
// the accepted sample order and every output beat against natural-order results.
module tb_fft_host_stream;
    localparam int RD_LAT = 2;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic [15:0] iDATA = '0;
    logic        iVALID = 1'b0;
    logic        oREADY;
    logic [16:0] oDATA;
    logic        oVALID;
    logic        iREADY = 1'b1;
    logic        oLAST;
    logic        oBUSY;
    logic [15:0] oFFT_DATA;
    logic [8:0]  oFFT_ADDR_WR;
    logic [3:0]  oFFT_WE;
    logic [8:0]  oFFT_ADDR_RD;
    logic [16:0] iFFT_DATA_RE_0, iFFT_DATA_RE_1, iFFT_DATA_RE_2, iFFT_DATA_RE_3;
    logic        oFFT_START;
    logic        iFFT_RDY = 1'b0;

    always #5 iCLK = ~iCLK;

    fft_host_stream #(.RD_LAT(RD_LAT), .FIFO_DEPTH(4)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST), .oBUSY(oBUSY),
        .oFFT_DATA(oFFT_DATA), .oFFT_ADDR_WR(oFFT_ADDR_WR), .oFFT_WE(oFFT_WE),
        .oFFT_ADDR_RD(oFFT_ADDR_RD), .iFFT_DATA_RE_0(iFFT_DATA_RE_0),
        .iFFT_DATA_RE_1(iFFT_DATA_RE_1), .iFFT_DATA_RE_2(iFFT_DATA_RE_2),
        .iFFT_DATA_RE_3(iFFT_DATA_RE_3), .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY)
    );

    // Core model: result of natural index n lives in bank n%4 at address n/4,
    // and read data appears RD_LAT cycles after the address.
    logic [16:0] res [2048];
    logic [8:0]  ad_q [RD_LAT];
    always @(posedge iCLK) begin
        ad_q[0] <= oFFT_ADDR_RD;
        for (int i = 1; i < RD_LAT; i++) ad_q[i] <= ad_q[i-1];
    end
    assign iFFT_DATA_RE_0 = res[{ad_q[RD_LAT-1], 2'd0}];
    assign iFFT_DATA_RE_1 = res[{ad_q[RD_LAT-1], 2'd1}];
    assign iFFT_DATA_RE_2 = res[{ad_q[RD_LAT-1], 2'd2}];
    assign iFFT_DATA_RE_3 = res[{ad_q[RD_LAT-1], 2'd3}];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state
    int cyc = 0;
    bit pend = 0;
    int pend_idx = 0;
    logic [15:0] pend_data;
    int acc_cnt = 0;
    logic [3:0]  wr_we_log   [2048];
    logic [8:0]  wr_addr_log [2048];
    logic [15:0] wr_data_log [2048];
    int last_we_cyc = -10, last_we_idx = -1;
    bit start_prev = 0;
    int starts = 0;
    int out_k = 0, frames_done = 0, first_cyc = 0, last_cyc = 0;
    bit held = 0;
    logic [16:0] held_data;
    bit held_last;
    bit rdy_m = 0;
    int rise_cyc = 0;

    always @(negedge iCLK) begin
        cyc++;
        if (iRESET) begin
            pend = 0; acc_cnt = 0; out_k = 0; held = 0; start_prev = 0;
        end else begin
            if (pend) begin
                logic [3:0] e_we;
                e_we = 4'(1 << (pend_idx % 4));
                chk("wr_we", {28'd0, oFFT_WE}, {28'd0, e_we});
                chk("wr_addr", {23'd0, oFFT_ADDR_WR}, pend_idx / 4);
                chk("wr_data", {16'd0, oFFT_DATA}, {16'd0, pend_data});
                wr_we_log[pend_idx] = oFFT_WE;
                wr_addr_log[pend_idx] = oFFT_ADDR_WR;
                wr_data_log[pend_idx] = oFFT_DATA;
                last_we_cyc = cyc;
                last_we_idx = pend_idx;
            end else begin
                chk("wr_idle", {28'd0, oFFT_WE}, 0);
            end
            pend = iVALID && oREADY;
            if (pend) begin
                pend_idx = acc_cnt;
                pend_data = iDATA;
                acc_cnt = (acc_cnt + 1) % 2048;
            end
            if (oFFT_START) begin
                chk("start_gap", cyc - last_we_cyc, 1);
                chk("start_idx", last_we_idx, 2047);
                chk("start_width", {31'd0, start_prev}, 0);
                starts++;
            end
            start_prev = oFFT_START;
            if (held) begin
                chk("stall_valid", {31'd0, oVALID}, 1);
                chk("stall_data", {15'd0, oDATA}, {15'd0, held_data});
                chk("stall_last", {31'd0, oLAST}, {31'd0, held_last});
            end
            if (oVALID && iREADY) begin
                chk("out_data", {15'd0, oDATA}, {15'd0, res[out_k]});
                chk("out_last", {31'd0, oLAST}, (out_k == 2047) ? 1 : 0);
                if (out_k == 0) first_cyc = cyc;
                if (out_k == 2047) begin
                    last_cyc = cyc;
                    frames_done++;
                    out_k = 0;
                end else out_k++;
            end
            held = oVALID && !iREADY;
            held_data = oDATA;
            held_last = oLAST;
        end
        if (iFFT_RDY && !rdy_m) rise_cyc = cyc;
        rdy_m = iFFT_RDY;
    end

    task automatic load_frame(input int gap_pct, input bit ramp);
        int n = 0;
        int guard = 0;
        while (n < 2048 && guard < 20000) begin
            bit v;
            @(posedge iCLK); #1;
            v = ($urandom_range(99) >= gap_pct);
            iVALID = v;
            iDATA = (v && ramp) ? 16'(n) : 16'($urandom);
            @(negedge iCLK);
            if (iVALID && oREADY) n++;
            guard++;
        end
        chk("load_count", n, 2048);
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        @(negedge iCLK);
        chk("ready_after_load", {31'd0, oREADY}, 0);
        chk("busy_after_load", {31'd0, oBUSY}, 1);
    endtask

    task automatic wait_start();
        int s0 = starts;
        for (int i = 0; i < 20 && starts == s0; i++) @(negedge iCLK);
        chk("start_seen", starts - s0, 1);
    endtask

    task automatic pulse_rdy();
        @(posedge iCLK); #1; iFFT_RDY = 1'b0;
        repeat (3) @(posedge iCLK);
        #1; iFFT_RDY = 1'b1;
    endtask

    task automatic unload(input int target, input int stall_pct);
        int guard = 0;
        while (frames_done < target && guard < 20000) begin
            @(posedge iCLK); #1;
            iREADY = ($urandom_range(99) >= stall_pct);
            guard++;
        end
        chk("unload_done", frames_done, target);
        @(posedge iCLK); #1; iREADY = 1'b1;
        @(negedge iCLK);
        chk("ready_after_unload", {31'd0, oREADY}, 1);
        chk("busy_after_unload", {31'd0, oBUSY}, 0);
        chk("valid_after_unload", {31'd0, oVALID}, 0);
    endtask

    typedef struct {
        int         idx;
        logic [3:0] we;
        logic [8:0] addr;
    } wr_vec_t;

    wr_vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0,    4'b0001, 9'd0};
        tbl[1] = '{1,    4'b0010, 9'd0};
        tbl[2] = '{2,    4'b0100, 9'd0};
        tbl[3] = '{3,    4'b1000, 9'd0};
        tbl[4] = '{4,    4'b0001, 9'd1};
        tbl[5] = '{7,    4'b1000, 9'd1};
        tbl[6] = '{1024, 4'b0001, 9'd256};
        tbl[7] = '{2046, 4'b0100, 9'd511};
        tbl[8] = '{2047, 4'b1000, 9'd511};
        for (int n = 0; n < 2048; n++) res[n] = 17'(n);

        // Reset state
        repeat (3) @(negedge iCLK);
        chk("rst_ready", {31'd0, oREADY}, 1);
        chk("rst_busy", {31'd0, oBUSY}, 0);
        chk("rst_valid", {31'd0, oVALID}, 0);
        chk("rst_last", {31'd0, oLAST}, 0);
        chk("rst_data", {15'd0, oDATA}, 0);
        chk("rst_start", {31'd0, oFFT_START}, 0);
        chk("rst_we", {28'd0, oFFT_WE}, 0);
        chk("rst_addr_wr", {23'd0, oFFT_ADDR_WR}, 0);
        chk("rst_addr_rd", {23'd0, oFFT_ADDR_RD}, 0);
        chk("rst_fft_data", {16'd0, oFFT_DATA}, 0);
        @(posedge iCLK); #1; iRESET = 1'b0;

        // Frame 1: ramp load, bank model 4*addr+bank, full-rate unload
        load_frame(0, 1'b1);
        wait_start();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl_we[%0d]", tbl[i].idx), {28'd0, wr_we_log[tbl[i].idx]}, {28'd0, tbl[i].we});
            chk($sformatf("tbl_addr[%0d]", tbl[i].idx), {23'd0, wr_addr_log[tbl[i].idx]}, {23'd0, tbl[i].addr});
            chk($sformatf("tbl_data[%0d]", tbl[i].idx), {16'd0, wr_data_log[tbl[i].idx]}, tbl[i].idx);
        end
        repeat (4) @(posedge iCLK);
        #1; iFFT_RDY = 1'b1;
        unload(1, 0);
        chk("first_latency", first_cyc - rise_cyc, RD_LAT + 2);
        chk("burst_length", last_cyc - first_cyc, 2047);

        // Frame 2: gappy random input, stale RDY level, random backpressure
        for (int n = 0; n < 2048; n++) res[n] = 17'($urandom);
        load_frame(35, 1'b0);
        wait_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            chk("wait_ignores_level", {31'd0, oVALID}, 0);
            chk("wait_busy", {31'd0, oBUSY}, 1);
        end
        pulse_rdy();
        unload(2, 30);

        // Frame 3: reset in the middle of the unload
        for (int n = 0; n < 2048; n++) res[n] = 17'($urandom);
        load_frame(0, 1'b0);
        wait_start();
        pulse_rdy();
        for (int i = 0; i < 5000 && out_k < 700; i++) @(negedge iCLK);
        chk("reached_700", out_k, 700);
        #2; iRESET = 1'b1; iFFT_RDY = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, oVALID}, 0);
        chk("midrst_ready", {31'd0, oREADY}, 1);
        chk("midrst_busy", {31'd0, oBUSY}, 0);
        chk("midrst_addr_rd", {23'd0, oFFT_ADDR_RD}, 0);
        repeat (2) @(negedge iCLK);
        @(posedge iCLK); #1; iRESET = 1'b0;

        // Frame 4: load restarts at bank 0 / address 0 and completes normally
        load_frame(10, 1'b0);
        chk("post_rst_we0", {28'd0, wr_we_log[0]}, 1);
        chk("post_rst_addr0", {23'd0, wr_addr_log[0]}, 0);
        wait_start();
        pulse_rdy();
        unload(3, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_host_stream.md
Name: fft_host_stream

Overview:
- Host-side streaming front end for the 2048-point, 4-bank FFT core.
- Load phase: accepts a valid/ready stream of 16-bit real samples and writes them into the core's four input banks through the core's external write interface.
- Then pulses the core's start input and waits for the core's ready output.
- Unload phase: reads the 17-bit real results back in natural order through the core's external read interface and presents them as a backpressured output stream with an end-of-frame marker.

Parameters:
- RD_LAT, 2: cycles from oFFT_ADDR_RD change to valid data on iFFT_DATA_RE_x.
- FIFO_DEPTH, 4: output skid FIFO entries; must be at least RD_LAT+2.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iDATA  in  16  input sample, two's complement.
- iVALID  in  1  input sample valid.
- oREADY  out  1  block accepts input sample.
- oDATA  out  17  output result (real part), two's complement.
- oVALID  out  1  output result valid.
- iREADY  in  1  downstream accepts result.
- oLAST  out  1  marks result k=2047.
- oBUSY  out  1  high in any state other than LOAD.
- oFFT_DATA  out  16  write data to the core (shared by all banks).
- oFFT_ADDR_WR  out  9  write address, fanned to all four bank write-address inputs.
- oFFT_WE  out  4  one-hot bank write enables.
- oFFT_ADDR_RD  out  9  read address, fanned to all four bank read-address inputs.
- iFFT_DATA_RE_0..3  in  17 each  bank read data.
- oFFT_START  out  1  core start pulse.
- iFFT_RDY  in  1  core done level.

Behaviour:
- Reset (asynchronous):
  - State LOAD; all counters 0; FIFO empty; previous-RDY register 0.
  - oREADY=1, oBUSY=0.
  - oVALID=0, oLAST=0, oDATA=0.
  - oFFT_START=0, oFFT_WE=0, oFFT_ADDR_WR=0, oFFT_ADDR_RD=0, oFFT_DATA=0.
- Sample mapping: sample/result index n goes to bank n[1:0], address n[10:2]. Input and output use the same mapping.
- State LOAD:
  - oREADY=1.
  - Each cycle with iVALID&oREADY, on the next cycle: oFFT_DATA=iDATA, oFFT_ADDR_WR=cnt[10:2], oFFT_WE=1<<cnt[1:0]; cnt increments.
  - oFFT_WE is 0 in every cycle without an accepted sample. Gaps in iVALID are allowed.
  - On accepting cnt=2047: go to FLUSH and drop oREADY.
- State FLUSH (1 cycle): the last WE pulse is on the outputs. Go to START.
- State START (1 cycle): oFFT_START=1, so start comes exactly 1 cycle after the last WE pulse. Go to WAIT.
- State WAIT:
  - Go to UNLOAD on a rising edge of iFFT_RDY only (current=1, previous=0).
  - A level that stays high from a previous frame is ignored.
- State UNLOAD:
  - A read-index counter rd issues one read per cycle: oFFT_ADDR_RD=rd[10:2]. The bank select rd[1:0] is delayed RD_LAT cycles in a shift register, alongside a valid bit.
  - A read issues only if fifo_count + in_flight < FIFO_DEPTH. This guarantees no result is lost under backpressure.
  - Returned data is selected by the delayed bank select and pushed into the FIFO, tagged last when index=2047.
  - FIFO head drives oDATA, oVALID and oLAST, all registered.
  - Pop on oVALID&iREADY.
  - Throughput is 1 result/cycle with iREADY held high, after an initial RD_LAT+1 cycle latency.
  - After the issue counter passes 2047, no more reads. When the beat with oLAST is accepted, go to LOAD with all counters cleared.
- Output stability: oDATA and oLAST hold stable while oVALID=1 and iREADY=0.
- Simultaneous push and pop with the FIFO full: allowed; count is unchanged.
- Reset mid-operation: immediate return to the reset state. A partial frame is discarded, and the core is not restarted.

Test Plan:
1. Reset, then stream ramp 0..2047 with iVALID=1 → oFFT_WE cycles 0001,0010,0100,1000; oFFT_ADDR_WR increments every 4 writes to 511; sample 2047 lands at bank 3, address 511; oFFT_START is a 1-cycle pulse 1 cycle after that write; oREADY=0 afterwards.
2. Input with random iVALID gaps → no WE pulse in gap cycles; same final mapping as scenario 1.
3. iFFT_RDY held 1 before START, dropping during WAIT, then rising → UNLOAD begins only on the new rising edge.
4. Bank model returning value = 4·addr + bank, iREADY=1 → oDATA sequence 0,1,…,2047 with one beat per cycle after the initial latency; oLAST only on 2047; block returns to LOAD with oREADY=1.
5. Random iREADY (30% low) during unload → all 2048 values in order; no duplicates or drops; stable outputs while stalled.
6. Assert iRESET at result 700 of unload → oVALID=0 immediately; oREADY=1; next frame loads from bank 0, address 0.
